// File: rtl/dropout_mask_replay.sv
// Regenerates the forward-dropout keep mask from a shared Galois LFSR and gates a returning byte stream with it.
// Optional drop statistics counter built only when DROPOUT_STATS_EN is defined.
module dropout_mask_replay #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
    parameter logic [LFSR_W-1:0] TAPS = 16'hB400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  data_out,
    output logic [WIDTH-1:0]  mask_out,
    output logic [15:0]       drop_count
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_data;
    logic [WIDTH-1:0]  r_mask;

    logic              w_in_ready;
    logic              w_accept;
    logic [WIDTH-1:0]  w_mask;
    logic [LFSR_W-1:0] w_lfsr_next;
    logic [LFSR_W-1:0] w_seed_val;

    assign w_mask      = r_lfsr[WIDTH-1:0];
    assign w_in_ready  = enable & ~seed_load & (~r_out_valid | out_ready);
    assign w_accept    = enable & in_valid & w_in_ready;
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    // A zero seed would lock the LFSR at zero forever.
    assign w_seed_val  = (seed == '0) ? SEED : seed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr      <= SEED;
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_mask      <= '0;
        end else if (enable) begin
            if (seed_load) begin
                r_lfsr <= w_seed_val;
            end else if (w_accept) begin
                r_lfsr <= w_lfsr_next;
            end

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_data      <= data_in & w_mask;
                r_mask      <= w_mask;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef DROPOUT_STATS_EN
    logic [15:0] r_drop_count;
    logic [15:0] w_zeros;
    logic [16:0] w_drop_sum;

    always_comb begin
        w_zeros = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_zeros = w_zeros + 16'(~w_mask[i]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop_count} + {1'b0, w_zeros};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_accept) begin
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data;
    assign mask_out  = r_mask;

endmodule

// File: doc/dropout_mask_replay.md
# dropout_mask_replay

Backward-path companion to the forward random-dropout stage: it regenerates, beat for beat, the same pseudo-random keep mask that the forward stage applied, and gates a returning byte stream (gradients or error flags) with it. Both ends share a seed and LFSR polynomial, so their masks stay in lockstep as long as beat counts match. It sits between the tile's input pins and the output byte, behind a valid/ready handshake with one output register.

## Interface
- `WIDTH`, 8: data and mask width in bits; must be ≤ `LFSR_W`.
- `LFSR_W`, 16: LFSR state width.
- `SEED`, 16'hACE1: reset value of the LFSR; also substituted whenever a zero seed is loaded.
- `TAPS`, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: block enable; low freezes all state.
- `seed_load` in 1: load `seed` into the LFSR this cycle.
- `seed` in `LFSR_W`: seed value.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `data_in` in `WIDTH`: returning data beat.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the output beat.
- `data_out` out `WIDTH`: `data_in & mask`, registered.
- `mask_out` out `WIDTH`: the mask applied to the beat in `data_out`.
- `drop_count` out 16: saturating count of dropped bit positions (see Configuration).

## Operation
- Mask for a beat = `lfsr[WIDTH-1:0]` at the accept cycle; 1 = keep, 0 = drop.
- Accept when `enable & in_valid & in_ready`. On accept: `data_out <= data_in & mask`, `mask_out <= mask`, `out_valid <= 1`, LFSR advances one Galois step (`lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0)`).
- LFSR advances only on accept, never on idle, stall or disabled cycles.
- `in_ready = enable & ~seed_load & (~out_valid | out_ready)`.
- Output handshake: `out_valid` clears on `out_ready` with no new accept in that cycle; with a simultaneous accept it stays 1 and the register takes the new beat.
- `seed_load` (with `enable` high): `lfsr <= (seed == 0) ? SEED : seed`. No accept that cycle. A pending output beat is unaffected.
- `enable` low: `in_ready = 0`; `out_valid`, `data_out`, `mask_out`, `lfsr` and `drop_count` hold. `out_ready` is ignored.
- `drop_count` adds the number of zero bits in the mask on each accept, saturating at 16'hFFFF. It clears only on reset.

## Timing
- Reset values: `out_valid = 0`, `data_out = 0`, `mask_out = 0`, `drop_count = 0`, `lfsr = SEED`. `in_ready` becomes 1 in the first cycle after reset deasserts if `enable = 1`.
- Latency: a beat accepted at edge N is visible on `data_out` after edge N (1 cycle).
- Throughput: 1 beat/cycle while `out_ready = 1`.
- Reset asserted mid-stream: drops any pending output beat immediately (asynchronous) and restores `lfsr = SEED`.
- The LFSR never reaches the all-zero state.

## Configuration
- `DROPOUT_STATS_EN` defined: `drop_count` logic is built as described above.
- `DROPOUT_STATS_EN` not defined: no counter is built and `drop_count` is tied to 0. Masking and handshake behaviour are unchanged.

## Test plan
- Reset, then `data_in = 8'hFF`, valid for 3 beats with `out_ready = 1`: `data_out` = 8'hE1, 8'h70, 8'h38. `drop_count` reads 4, 9, 14 (stats enabled).
- Hold `out_ready = 0` after the first accept: `in_ready = 0`, `data_out` holds 8'hE1 and the LFSR stays at 16'hE270. Release `out_ready`: the next beat gives 8'h70.
- Assert `seed_load` with `seed = 0`, then feed `data_in = 8'hFF`: the output is 8'hE1, because the zero seed is replaced by `SEED`. `in_ready = 0` during the load cycle.
- Drop `enable` for 5 cycles mid-stream with `in_valid = 1`: no accepts, all outputs frozen. Restore `enable`: the mask sequence resumes without skipping any value.
- Assert `reset` asynchronously while `out_valid = 1`: `out_valid`, `data_out` and `drop_count` go to 0 before the next clock edge. The next beat of 8'hFF gives 8'hE1.
- Force `drop_count` near saturation, e.g. preload via a long run: it stops at 16'hFFFF with no wrap. With `DROPOUT_STATS_EN` undefined, it stays 0.
